// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control sequencer: fetches into an instruction register and
// walks each instruction through FETCH/DECODE/EXEC/MEM/WB with Moore-decoded strobes.
module multicycle_control #(
    parameter logic [31:0] RESET_IR = 32'h00000013
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic        mem_ack,
    input  logic        alu_zero,
    output logic [3:0]  aluop,
    output logic [1:0]  alumux1_sel,
    output logic [1:0]  alumux2_sel,
    output logic [31:0] imm,
    output logic [4:0]  rs1_addr,
    output logic [4:0]  rs2_addr,
    output logic [4:0]  rd_addr,
    output logic        reg_we,
    output logic        mem_re,
    output logic        mem_we,
    output logic        wb_sel,
    output logic        pc_we,
    output logic        pc_sel,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD  = 4'd0;
    localparam logic [3:0] ALU_SUB  = 4'd1;
    localparam logic [3:0] ALU_AND  = 4'd2;
    localparam logic [3:0] ALU_OR   = 4'd3;
    localparam logic [3:0] ALU_XOR  = 4'd4;
    localparam logic [3:0] ALU_SLL  = 4'd5;
    localparam logic [3:0] ALU_SRL  = 4'd6;
    localparam logic [3:0] ALU_SRA  = 4'd7;
    localparam logic [3:0] ALU_SLT  = 4'd8;
    localparam logic [3:0] ALU_SLTU = 4'd9;

    localparam logic [1:0] MUX1_RS1    = 2'd0;
    localparam logic [1:0] MUX1_PC     = 2'd1;
    localparam logic [1:0] MUX1_ZERO   = 2'd2;
    localparam logic [1:0] MUX2_RS2    = 2'd0;
    localparam logic [1:0] MUX2_IMM    = 2'd1;
    localparam logic [1:0] MUX2_CONST4 = 2'd2;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_TRAP   = 3'd5
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] ir;
    logic        illegal_q;
    logic        store_retire;

    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        is_op, is_opimm, is_load, is_store, is_branch, is_jal, is_lui;
    logic        opcode_ok;
    logic        branch_ok;
    logic [3:0]  exec_aluop;
    logic [1:0]  exec_mux1;
    logic [1:0]  exec_mux2;

    // funct7[5] selects SUB only for register-register ops; for shifts it selects SRA.
    function automatic logic [3:0] decode_aluop(input logic [2:0] f3,
                                                input logic       f7b5,
                                                input logic       is_reg);
        case (f3)
            3'b000:  decode_aluop = (is_reg && f7b5) ? ALU_SUB : ALU_ADD;
            3'b001:  decode_aluop = ALU_SLL;
            3'b010:  decode_aluop = ALU_SLT;
            3'b011:  decode_aluop = ALU_SLTU;
            3'b100:  decode_aluop = ALU_XOR;
            3'b101:  decode_aluop = f7b5 ? ALU_SRA : ALU_SRL;
            3'b110:  decode_aluop = ALU_OR;
            default: decode_aluop = ALU_AND;
        endcase
    endfunction

    assign opcode    = ir[6:0];
    assign funct3    = ir[14:12];
    assign rs1_addr  = ir[19:15];
    assign rs2_addr  = ir[24:20];
    assign rd_addr   = ir[11:7];

    assign is_op     = (opcode == OPC_OP);
    assign is_opimm  = (opcode == OPC_OPIMM);
    assign is_load   = (opcode == OPC_LOAD);
    assign is_store  = (opcode == OPC_STORE);
    assign is_branch = (opcode == OPC_BRANCH);
    assign is_jal    = (opcode == OPC_JAL);
    assign is_lui    = (opcode == OPC_LUI);
    assign opcode_ok = is_op | is_opimm | is_load | is_store | is_branch | is_jal | is_lui;
    assign branch_ok = is_branch && (funct3[2:1] == 2'b00);

    always_comb begin
        imm = 32'b0;
        case (opcode)
            OPC_OPIMM,
            OPC_LOAD:   imm = {{20{ir[31]}}, ir[31:20]};
            OPC_STORE:  imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
            OPC_BRANCH: imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
            OPC_LUI:    imm = {ir[31:12], 12'b0};
            OPC_JAL:    imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
            default:    imm = 32'b0;
        endcase
    end

    always_comb begin
        exec_aluop = ALU_ADD;
        exec_mux1  = MUX1_RS1;
        exec_mux2  = MUX2_RS2;
        case (opcode)
            OPC_OP:     exec_aluop = decode_aluop(funct3, ir[30], 1'b1);
            OPC_OPIMM: begin
                exec_aluop = decode_aluop(funct3, ir[30], 1'b0);
                exec_mux2  = MUX2_IMM;
            end
            OPC_LOAD,
            OPC_STORE:  exec_mux2  = MUX2_IMM;
            OPC_BRANCH: exec_aluop = ALU_SUB;
            OPC_JAL: begin
                exec_mux1 = MUX1_PC;
                exec_mux2 = MUX2_CONST4;
            end
            OPC_LUI: begin
                exec_mux1 = MUX1_ZERO;
                exec_mux2 = MUX2_IMM;
            end
            default: ;
        endcase
    end

    // The store's pc+4 update is registered so that no strobe depends on mem_ack
    // combinationally; the pulse lands in the FETCH cycle following the ack.
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= S_FETCH;
            ir           <= RESET_IR;
            illegal_q    <= 1'b0;
            store_retire <= 1'b0;
        end else begin
            state        <= state_next;
            store_retire <= (state == S_MEM) && is_store && mem_ack;
            if (state == S_FETCH && instr_valid)
                ir <= instr;
            if (state_next == S_TRAP)
                illegal_q <= 1'b1;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            S_FETCH:  if (instr_valid) state_next = S_DECODE;
            S_DECODE: state_next = opcode_ok ? S_EXEC : S_TRAP;
            S_EXEC: begin
                if (is_op || is_opimm || is_jal || is_lui)
                    state_next = S_WB;
                else if (is_load || is_store)
                    state_next = S_MEM;
                else if (branch_ok)
                    state_next = S_FETCH;
                else
                    state_next = S_TRAP;
            end
            S_MEM:    if (mem_ack) state_next = is_store ? S_FETCH : S_WB;
            S_WB:     state_next = S_FETCH;
            S_TRAP:   state_next = S_TRAP;
            default:  state_next = S_FETCH;
        endcase
    end

    always_comb begin
        instr_ready = 1'b0;
        aluop       = ALU_ADD;
        alumux1_sel = MUX1_RS1;
        alumux2_sel = MUX2_RS2;
        reg_we      = 1'b0;
        mem_re      = 1'b0;
        mem_we      = 1'b0;
        wb_sel      = 1'b0;
        pc_we       = 1'b0;
        pc_sel      = 1'b0;
        case (state)
            S_FETCH: begin
                instr_ready = 1'b1;
                pc_we       = store_retire;
            end
            S_EXEC: begin
                aluop       = exec_aluop;
                alumux1_sel = exec_mux1;
                alumux2_sel = exec_mux2;
                if (branch_ok) begin
                    pc_we  = 1'b1;
                    pc_sel = funct3[0] ? ~alu_zero : alu_zero;
                end
            end
            S_MEM: begin
                alumux1_sel = exec_mux1;
                alumux2_sel = exec_mux2;
                mem_re      = is_load;
                mem_we      = is_store;
            end
            S_WB: begin
                reg_we = 1'b1;
                pc_we  = 1'b1;
                wb_sel = is_load;
                pc_sel = is_jal;
            end
            default: ;
        endcase
    end

    assign illegal = illegal_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed-vector bench for multicycle_control with hand-computed expectations.
module tb_multicycle_control;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        mem_ack;
    logic        alu_zero;
    logic [3:0]  aluop;
    logic [1:0]  alumux1_sel;
    logic [1:0]  alumux2_sel;
    logic [31:0] imm;
    logic [4:0]  rs1_addr, rs2_addr, rd_addr;
    logic        reg_we, mem_re, mem_we, wb_sel, pc_we, pc_sel, illegal;

    int checks_total  = 0;
    int checks_passed = 0;

    multicycle_control dut (
        .clk(clk), .rst(rst), .instr(instr), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .mem_ack(mem_ack), .alu_zero(alu_zero),
        .aluop(aluop), .alumux1_sel(alumux1_sel), .alumux2_sel(alumux2_sel),
        .imm(imm), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .rd_addr(rd_addr),
        .reg_we(reg_we), .mem_re(mem_re), .mem_we(mem_we), .wb_sel(wb_sel),
        .pc_we(pc_we), .pc_sel(pc_sel), .illegal(illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_total++;
        if (got === exp)
            checks_passed++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic issue(input logic [31:0] i);
        instr       = i;
        instr_valid = 1'b1;
        step();
        instr_valid = 1'b0;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while (!instr_ready && n < 20) begin
            step();
            n++;
        end
        check({tag, "_drain"}, instr_ready, 1);
    endtask

    task automatic exec_probe(input string tag, input logic [31:0] i,
                              input logic [3:0] a, input logic [1:0] m1, input logic [1:0] m2);
        issue(i);
        step();
        check({tag, "_aluop"}, aluop, a);
        check({tag, "_mux1"}, alumux1_sel, m1);
        check({tag, "_mux2"}, alumux2_sel, m2);
        drain(tag);
    endtask

    // Zero-wait memory: counts cycles to the next instr_ready and pc_we pulses on the way.
    task automatic measure(input string tag, input logic [31:0] i, input int exp_lat);
        int lat = 1;
        int pcw = 0;
        mem_ack = 1'b1;
        issue(i);
        while (!instr_ready && lat < 20) begin
            pcw += int'(pc_we);
            step();
            lat++;
        end
        pcw += int'(pc_we);
        check({tag, "_lat"}, lat, exp_lat);
        check({tag, "_pcwe_cnt"}, pcw, 1);
        mem_ack = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        int bad;
        rst = 1'b1; instr = 32'h0; instr_valid = 1'b0; mem_ack = 1'b0; alu_zero = 1'b0;
        step();
        step();
        rst = 1'b0;

        check("rst_ready", instr_ready, 1);
        check("rst_aluop", aluop, 0);
        check("rst_mux", {alumux1_sel, alumux2_sel}, 0);
        check("rst_strobes", {reg_we, mem_re, mem_we, pc_we, wb_sel, pc_sel}, 0);
        check("rst_illegal", illegal, 0);
        check("rst_imm", imm, 0);
        check("rst_rd", rd_addr, 0);

        // add x3,x1,x2
        issue(32'h002081B3);
        check("add_dec_ready", instr_ready, 0);
        check("add_dec_rd", rd_addr, 3);
        check("add_dec_rs", {rs1_addr, rs2_addr}, {5'd1, 5'd2});
        check("add_dec_we", reg_we, 0);
        step();
        check("add_ex_aluop", aluop, 0);
        check("add_ex_mux", {alumux1_sel, alumux2_sel}, 0);
        check("add_ex_pcwe", pc_we, 0);
        step();
        check("add_wb_regwe", reg_we, 1);
        check("add_wb_pcwe", pc_we, 1);
        check("add_wb_pcsel", pc_sel, 0);
        check("add_wb_wbsel", wb_sel, 0);
        step();
        check("add_c4_ready", instr_ready, 1);
        check("add_c4_pcwe", pc_we, 0);

        // srai x1,x2,4
        issue(32'h40415093);
        check("srai_imm", imm, 32'h404);
        step();
        check("srai_aluop", aluop, 7);
        check("srai_mux2", alumux2_sel, 1);
        drain("srai");
        exec_probe("sub", 32'h40208033, 4'd1, 2'd0, 2'd0);
        exec_probe("sltu", 32'h0020B033, 4'd9, 2'd0, 2'd0);
        exec_probe("jal_ex", 32'h010000EF, 4'd0, 2'd1, 2'd2);
        exec_probe("lui_ex", 32'h123452B7, 4'd0, 2'd2, 2'd1);

        // jal x1,16: WB selects pc+imm
        issue(32'h010000EF);
        check("jal_imm", imm, 32'h10);
        step();
        step();
        check("jal_wb_pcsel", pc_sel, 1);
        check("jal_wb_regwe", reg_we, 1);
        drain("jal");

        // lw x2,-4(x1) with mem_ack on the third MEM cycle
        issue(32'hFFC0A103);
        check("lw_imm", imm, 32'hFFFFFFFC);
        step();
        check("lw_ex_aluop", aluop, 0);
        check("lw_ex_mux2", alumux2_sel, 1);
        step();
        check("lw_m1_re", mem_re, 1);
        check("lw_m1_mux2", alumux2_sel, 1);
        check("lw_m1_aluop", aluop, 0);
        step();
        check("lw_m2_re", mem_re, 1);
        check("lw_m2_regwe", reg_we, 0);
        step();
        check("lw_m3_re", mem_re, 1);
        mem_ack = 1'b1;
        step();
        mem_ack = 1'b0;
        check("lw_wb_re", mem_re, 0);
        check("lw_wb_wbsel", wb_sel, 1);
        check("lw_wb_regwe", reg_we, 1);
        check("lw_wb_pcwe", pc_we, 1);
        step();
        check("lw_total_ready", instr_ready, 1);

        // beq / bne with alu_zero=1, then bne with alu_zero=0
        alu_zero = 1'b1;
        issue(32'h00208463);
        check("beq_imm", imm, 32'h8);
        step();
        check("beq_aluop", aluop, 1);
        check("beq_pcwe", pc_we, 1);
        check("beq_pcsel", pc_sel, 1);
        step();
        check("beq_next_ready", instr_ready, 1);
        issue(32'h00209463);
        step();
        check("bne_z1_pcwe", pc_we, 1);
        check("bne_z1_pcsel", pc_sel, 0);
        alu_zero = 1'b0;
        #1;
        check("bne_z0_pcsel", pc_sel, 1);
        step();
        check("bne_next_ready", instr_ready, 1);

        measure("op", 32'h002081B3, 4);
        measure("opimm", 32'h40415093, 4);
        measure("lui", 32'h123452B7, 4);
        measure("jal", 32'h010000EF, 4);
        measure("beq", 32'h00208463, 3);
        measure("sw", 32'h0020A023, 4);
        check("sw_retire_pcsel", pc_sel, 0);
        measure("lw", 32'hFFC0A103, 5);

        // illegal opcode: TRAP held with inputs toggling
        issue(32'h0000007F);
        check("ill_dec_flag", illegal, 0);
        step();
        check("ill_flag", illegal, 1);
        check("ill_ready", instr_ready, 0);
        bad = 0;
        instr_valid = 1'b1;
        mem_ack = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step();
            if (!illegal || instr_ready || reg_we || mem_re || mem_we || pc_we) bad++;
        end
        instr_valid = 1'b0;
        mem_ack = 1'b0;
        check("ill_hold", bad, 0);
        do_reset();
        check("ill_rst_flag", illegal, 0);
        check("ill_rst_ready", instr_ready, 1);

        // unsupported branch funct3 traps from EXEC without a pc update
        issue(32'h0020A463);
        step();
        check("badbr_pcwe", pc_we, 0);
        step();
        check("badbr_flag", illegal, 1);
        do_reset();
        check("badbr_rst_ready", instr_ready, 1);

        // reset while a store waits in MEM
        issue(32'h0020A023);
        step();
        step();
        check("rstmem_we", mem_we, 1);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rstmem_memwe", mem_we, 0);
        check("rstmem_pcwe", pc_we, 0);
        check("rstmem_ready", instr_ready, 1);
        check("rstmem_ir_rs", {rs1_addr, rs2_addr, rd_addr}, 0);
        check("rstmem_ir_imm", imm, 0);
        step();
        check("rstmem_pcwe2", pc_we, 0);

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end

endmodule
